// File: rtl/dsm_pkg.sv
// Shared types and helpers for the delta-sigma receive path.
package dsm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    COMB = 1'b1
  } cic_state_t;

  // Internal CIC width: bit growth of ORDER stages at ratio 2^log2_decim,
  // plus one bit for the +/-1 input and one sign bit.
  function automatic int cic_aw(input int order, input int log2_decim);
    return order * log2_decim + 2;
  endfunction

  // Arithmetic right shift, then clamp to a signed out_width range.
  // The result is returned in a wide container; callers truncate it.
  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] value,
                                                  input int shift,
                                                  input int out_width);
    logic signed [63:0] sh;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sh = value >>> shift;
    hi = (64'sd1 <<< (out_width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_width - 1));
    if (sh > hi)      return hi;
    else if (sh < lo) return lo;
    else              return sh;
  endfunction

endpackage

// File: rtl/cic_integrator_chain.sv
// Pipelined CIC integrator cascade with decimation phase counter and
// snapshot of the last integrator's next-state value.
module cic_integrator_chain
  import dsm_pkg::*;
#(
  parameter int ORDER      = 3,
  parameter int LOG2_DECIM = 5,
  parameter int AW         = 17
) (
  input  logic                 aclk,
  input  logic                 rst,
  input  logic                 i_accept,
  input  logic                 i_bit,
  output logic                 o_cnt_last,
  output logic                 o_snap_stb,
  output logic signed [AW-1:0] o_snap_val
);

  logic signed [AW-1:0]   r_integ [ORDER];
  logic signed [AW-1:0]   w_next  [ORDER];
  logic signed [AW-1:0]   w_x;
  logic [LOG2_DECIM-1:0]  r_cnt;

  // Bit 1 is +1, bit 0 is -1 (all ones in two's complement).
  assign w_x = i_bit ? AW'(1) : {AW{1'b1}};

  // Next-state of each integrator; stage k adds the registered stage k-1,
  // so each stage contributes one beat of delay. Sums wrap modulo 2^AW.
  always_comb begin
    w_next[0] = r_integ[0] + w_x;
    for (int k = 1; k < ORDER; k++) begin
      w_next[k] = r_integ[k] + r_integ[k-1];
    end
  end

  // Integrators and phase counter advance only on accepted input beats.
  always_ff @(posedge aclk) begin
    if (rst) begin
      for (int k = 0; k < ORDER; k++) r_integ[k] <= '0;
      r_cnt <= '0;
    end else if (i_accept) begin
      for (int k = 0; k < ORDER; k++) r_integ[k] <= w_next[k];
      r_cnt <= r_cnt + LOG2_DECIM'(1);
    end
  end

  assign o_cnt_last = &r_cnt;
  assign o_snap_stb = i_accept && o_cnt_last;
  assign o_snap_val = w_next[ORDER-1];

endmodule

// File: rtl/dsm_cic_decimator.sv
// CIC (sinc^ORDER) decimator turning a 1-bit DSM stream into signed
// samples on an AXI-stream master. Combs run serially, one per cycle.
module dsm_cic_decimator
  import dsm_pkg::*;
#(
  parameter int ORDER      = 3,
  parameter int LOG2_DECIM = 5,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                        aclk,
  input  logic                        rst,
  input  logic                        s_axis_data_tdata,
  input  logic                        s_axis_data_tvalid,
  output logic                        s_axis_data_tready,
  output logic signed [OUT_WIDTH-1:0] m_axis_data_tdata,
  output logic                        m_axis_data_tvalid,
  input  logic                        m_axis_data_tready
);

  localparam int AW    = cic_aw(ORDER, LOG2_DECIM);
  localparam int SHIFT = ORDER * LOG2_DECIM - (OUT_WIDTH - 1);
  localparam int KW    = (ORDER > 1) ? $clog2(ORDER) : 1;

  cic_state_t                  r_state;
  logic [KW-1:0]               r_k;
  logic signed [AW-1:0]        r_v;
  logic signed [AW-1:0]        r_comb_dly [ORDER];
  logic signed [OUT_WIDTH-1:0] r_tdata;
  logic                        r_tvalid;

  logic                        w_accept;
  logic                        w_cnt_last;
  logic                        w_snap_stb;
  logic signed [AW-1:0]        w_snap_val;
  logic signed [AW-1:0]        w_d;
  logic signed [OUT_WIDTH-1:0] w_sat;

  // Stall only the snapshot beat while a previous sample is still in the
  // comb pipe or waiting in the output register, so it is never overwritten.
  assign s_axis_data_tready = !(w_cnt_last && (r_state != IDLE || r_tvalid));
  assign w_accept           = s_axis_data_tvalid && s_axis_data_tready;

  cic_integrator_chain #(
    .ORDER      (ORDER),
    .LOG2_DECIM (LOG2_DECIM),
    .AW         (AW)
  ) u_integ (
    .aclk       (aclk),
    .rst        (rst),
    .i_accept   (w_accept),
    .i_bit      (s_axis_data_tdata),
    .o_cnt_last (w_cnt_last),
    .o_snap_stb (w_snap_stb),
    .o_snap_val (w_snap_val)
  );

  assign w_d   = r_v - r_comb_dly[r_k];
  assign w_sat = OUT_WIDTH'(sat_shift(64'(w_d), SHIFT, OUT_WIDTH));

  // Comb FSM, output register and output handshake.
  always_ff @(posedge aclk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_k      <= '0;
      r_v      <= '0;
      for (int k = 0; k < ORDER; k++) r_comb_dly[k] <= '0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
    end else begin
      if (r_tvalid && m_axis_data_tready) r_tvalid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_snap_stb) begin
            r_v     <= w_snap_val;
            r_k     <= '0;
            r_state <= COMB;
          end
        end
        COMB: begin
          r_comb_dly[r_k] <= r_v;
          r_v             <= w_d;
          if (r_k == KW'(ORDER - 1)) begin
            r_tdata  <= w_sat;
            r_tvalid <= 1'b1;
            r_state  <= IDLE;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m_axis_data_tdata  = r_tdata;
  assign m_axis_data_tvalid = r_tvalid;

endmodule

// File: tb/tb_dsm_cic_decimator.sv
// Randomized self-checking bench for dsm_cic_decimator against a
// convolution-based sinc^ORDER reference model.
module tb_dsm_cic_decimator;

  localparam int ORDER      = 3;
  localparam int LOG2_DECIM = 5;
  localparam int OUT_WIDTH  = 16;
  localparam int DECIM      = 1 << LOG2_DECIM;
  localparam int SH         = ORDER * LOG2_DECIM - (OUT_WIDTH - 1);
  localparam int KL         = ORDER * (DECIM - 1) + 1;

  logic                        aclk;
  logic                        rst;
  logic                        s_tdata;
  logic                        s_tvalid;
  logic                        s_tready;
  logic signed [OUT_WIDTH-1:0] m_tdata;
  logic                        m_tvalid;
  logic                        m_tready;

  int n_vec;
  int n_bad;
  int h [KL];
  int xq[$];
  int expq[$];
  int snapq[$];
  int cyc;
  int outs_seen;
  bit just_rst;
  bit const_on;
  int const_exp;
  int dut_sum;
  int e1, e2;

  dsm_cic_decimator #(
    .ORDER      (ORDER),
    .LOG2_DECIM (LOG2_DECIM),
    .OUT_WIDTH  (OUT_WIDTH)
  ) dut (
    .aclk               (aclk),
    .rst                (rst),
    .s_axis_data_tdata  (s_tdata),
    .s_axis_data_tvalid (s_tvalid),
    .s_axis_data_tready (s_tready),
    .m_axis_data_tdata  (m_tdata),
    .m_axis_data_tvalid (m_tvalid),
    .m_axis_data_tready (m_tready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, cyc=%0d want finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // Output m is the sinc^ORDER kernel applied to all beats up to the m-th
  // snapshot beat, delayed by ORDER-1 beats for the pipelined integrators.
  function automatic int model_out(input int m);
    int j, acc, lim, lo_i;
    j    = m * DECIM + DECIM - 1 - (ORDER - 1);
    acc  = 0;
    lo_i = (j - KL + 1 > 0) ? j - KL + 1 : 0;
    for (int i = lo_i; i <= j; i++) acc += xq[i] * h[j - i];
    acc = acc >>> SH;
    lim = 1 << (OUT_WIDTH - 1);
    if (acc > lim - 1) acc = lim - 1;
    else if (acc < -lim) acc = -lim;
    return acc;
  endfunction

  // Second-order error-feedback modulator, input scaled so +/-32768 is full scale.
  function automatic bit mod2_bit(input int u);
    int v, y, e;
    v  = u - 2 * e1 + e2;
    y  = (v >= 0) ? 32768 : -32768;
    e  = y - v;
    e2 = e1;
    e1 = e;
    return (y > 0);
  endfunction

  task automatic step(input bit vin, input bit bin, input bit rdy, input bit do_rst);
    bit exp_rdy, exp_vld;
    int ph;
    @(negedge aclk);
    rst      = do_rst;
    s_tvalid = vin;
    s_tdata  = bin;
    m_tready = rdy;
    #1;
    if (do_rst) begin
      xq.delete();
      expq.delete();
      snapq.delete();
      outs_seen = 0;
      just_rst  = 1'b1;
    end else begin
      if (just_rst) begin
        check_val("rst_tdata", m_tdata, 0);
        just_rst = 1'b0;
      end
      ph      = xq.size() % DECIM;
      exp_rdy = !(ph == DECIM - 1 && expq.size() > 0);
      exp_vld = (expq.size() > 0) && (cyc >= snapq[0] + ORDER + 1);
      check_val("s_tready", s_tready, exp_rdy);
      check_val("m_tvalid", m_tvalid, exp_vld);
      if (exp_vld) check_val("m_tdata", m_tdata, expq[0]);
      if (exp_vld && rdy) begin
        if (const_on && outs_seen >= ORDER) check_val("steady", m_tdata, const_exp);
        if (outs_seen >= ORDER && outs_seen < ORDER + 256) dut_sum += int'(m_tdata);
        void'(expq.pop_front());
        void'(snapq.pop_front());
        outs_seen++;
      end
      if (vin && exp_rdy) begin
        xq.push_back(bin ? 1 : -1);
        if (xq.size() % DECIM == 0) begin
          expq.push_back(model_out(xq.size() / DECIM - 1));
          snapq.push_back(cyc);
        end
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    int tmp [KL];
    int exp_sum, w, off, dut_mean, exp_mean, diff;
    bit found;
    n_vec = 0; n_bad = 0; cyc = 0; outs_seen = 0;
    just_rst = 0; const_on = 0; const_exp = 0; dut_sum = 0; e1 = 0; e2 = 0;
    rst = 1'b1; s_tvalid = 1'b0; s_tdata = 1'b0; m_tready = 1'b0;

    // Kernel: ORDER boxcars of length DECIM convolved together.
    for (int n = 0; n < KL; n++) h[n] = 0;
    h[0] = 1;
    for (int s = 0; s < ORDER; s++) begin
      for (int n = 0; n < KL; n++) begin
        tmp[n] = 0;
        for (int k = 0; k < DECIM; k++) if (n - k >= 0) tmp[n] += h[n - k];
      end
      h = tmp;
    end

    do_reset();
    do_reset();

    // All ones: steady output at positive full scale.
    const_on = 1; const_exp = 32767;
    for (int n = 0; n < 10 * DECIM; n++) step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int n = 0; n < 8; n++) step(1'b0, 1'b0, 1'b1, 1'b0);

    // All zeros: steady output at negative full scale.
    do_reset();
    const_exp = -32768;
    for (int n = 0; n < 10 * DECIM; n++) step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 8; n++) step(1'b0, 1'b0, 1'b1, 1'b0);

    // Alternating 1,0: steady output zero.
    do_reset();
    const_exp = 0;
    for (int n = 0; n < 10 * DECIM; n++) step(1'b1, (n % 2) == 0, 1'b1, 1'b0);
    for (int n = 0; n < 8; n++) step(1'b0, 1'b0, 1'b1, 1'b0);
    const_on = 0;

    // Sink stalled for 100 cycles with input valid every cycle.
    do_reset();
    for (int n = 0; n < 40; n++) step(1'b1, 1'($urandom_range(1)), 1'b1, 1'b0);
    for (int n = 0; n < 100; n++) step(1'b1, 1'($urandom_range(1)), 1'b0, 1'b0);
    for (int n = 0; n < 200; n++) step(1'b1, 1'($urandom_range(1)), 1'b1, 1'b0);

    // Random valid, ready and data.
    for (int n = 0; n < 800; n++)
      step($urandom_range(99) < 75, 1'($urandom_range(1)), $urandom_range(99) < 70, 1'b0);
    for (int n = 0; n < 60; n++) step(1'b0, 1'b0, 1'b1, 1'b0);

    // Reset pulse in the middle of a comb sequence.
    do_reset();
    const_on = 1; const_exp = 32767;
    for (int n = 0; n < 3 * DECIM + 8; n++) step(1'b1, 1'b1, 1'b1, 1'b0);
    found = 0;
    for (int n = 0; n < 4 * DECIM && !found; n++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0);
      if (snapq.size() > 0 && snapq[snapq.size() - 1] == cyc - 1) found = 1;
    end
    check_val("comb_reached", found, 1);
    do_reset();
    for (int n = 0; n < 10 * DECIM; n++) step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int n = 0; n < 8; n++) step(1'b0, 1'b0, 1'b1, 1'b0);
    const_on = 0;

    // DC tone from the modulator: offset-binary 0x4000 is -0.5 full scale.
    do_reset();
    dut_sum = 0; e1 = 0; e2 = 0;
    for (int n = 0; n < DECIM * (ORDER + 256) + 48; n++)
      step(1'b1, mod2_bit(32'h4000 - 32'h8000), 1'b1, 1'b0);
    for (int n = 0; n < 8; n++) step(1'b0, 1'b0, 1'b1, 1'b0);
    exp_sum = 0;
    for (int i = 0; i < xq.size(); i++) begin
      w = 0;
      for (int m = ORDER; m < ORDER + 256; m++) begin
        off = m * DECIM + DECIM - 1 - (ORDER - 1) - i;
        if (off >= 0 && off < KL) w += h[off];
      end
      exp_sum += xq[i] * w;
    end
    exp_sum  = exp_sum >>> SH;
    dut_mean = dut_sum / 256;
    exp_mean = exp_sum / 256;
    diff     = dut_sum - exp_sum;
    check_val("dc_mean", (diff <= 256 && diff >= -256) ? exp_mean : dut_mean, exp_mean);
    check_val("dc_outputs", outs_seen >= ORDER + 256, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
